// File: rtl/mux4_arbiter_if.sv
// Handshake bundle between the four datapath sources, the shared consumer
// and the round-robin arbiter that steers the 4:1 mux.
interface mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] select;
  logic       out_valid;
  logic       busy;

  modport master (
    output req, last, out_ready,
    input  grant, select, out_valid, busy
  );

  modport slave (
    input  req, last, out_ready,
    output grant, select, out_valid, busy
  );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 datapath: one grant at a time, bounded
// bursts, valid/ready downstream and zero-gap handover between requesters.
module mux4_arbiter #(
  parameter int MAX_BEATS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux4_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

  state_t     state_q;
  logic [3:0] grant_q;
  logic [1:0] select_q;
  logic [1:0] ptr_q;
  logic       busy_q;
  logic [7:0] cnt_q;

  logic [1:0] arb_base;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       any_req;
  logic       xfer;
  logic       release_now;

  assign bus.grant     = grant_q;
  assign bus.select    = select_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = busy_q & bus.req[select_q];

  assign xfer        = bus.out_valid & bus.out_ready;
  assign release_now = (xfer & (bus.last[select_q] | (cnt_q == LAST_CNT)))
                     | ~bus.req[select_q];
  assign any_req     = |bus.req;

  // While granted, the current owner becomes the lowest priority on release,
  // so arbitration starts from select rather than the stale ptr.
  assign arb_base = (state_q == GRANT) ? select_q : ptr_q;

  always_comb begin
    winner = arb_base;
    cand   = arb_base;
    for (int k = 4; k >= 1; k--) begin
      cand = arb_base + 2'(k);
      if (bus.req[cand]) begin
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      select_q <= 2'b00;
      ptr_q    <= 2'b11;
      busy_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= GRANT;
            grant_q  <= 4'b0001 << winner;
            select_q <= winner;
            busy_q   <= 1'b1;
            cnt_q    <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_q <= select_q;
            if (any_req) begin
              grant_q  <= 4'b0001 << winner;
              select_q <= winner;
              cnt_q    <= 8'd0;
            end else begin
              state_q <= IDLE;
              grant_q <= 4'b0000;
              busy_q  <= 1'b0;
            end
          end else if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux4_arbiter.sv
// Randomised and directed bench for mux4_arbiter against a burst-level
// ownership model; outputs are compared on every falling edge.
module tb_mux4_arbiter;
  localparam int MAX_BEATS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4_arbiter_if bus ();

  mux4_arbiter #(.MAX_BEATS(MAX_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port, how many beats it has moved, and who won last.
  int m_owner = -1;
  int m_ptr   = 3;
  int m_sel   = 0;
  int m_beats = 0;

  function automatic int pick(input int last_winner, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last_winner + k) % 4]) return (last_winner + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  w;
    bit  moved;
    bit  done;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 3;
      m_sel   = 0;
      m_beats = 0;
    end else if (m_owner < 0) begin
      w = pick(m_ptr, bus.req);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_beats = 0;
      end
    end else begin
      moved = bus.req[m_owner] && bus.out_ready;
      if (moved) m_beats++;
      done = !bus.req[m_owner] || (moved && (bus.last[m_owner] || m_beats == MAX_BEATS));
      if (done) begin
        $display("burst owner=%0d beats=%0d t=%0t", m_owner, m_beats, $time);
        m_ptr = m_owner;
        w = pick(m_ptr, bus.req);
        if (w < 0) begin
          m_owner = -1;
        end else begin
          m_owner = w;
          m_sel   = w;
          m_beats = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_grant;
    exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("model_grant", bus.grant, exp_grant);
    check("model_select", bus.select, m_sel);
    check("model_busy", bus.busy, (m_owner >= 0));
    check("model_out_valid", bus.out_valid, (m_owner >= 0) && bus.req[m_owner]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req       = 4'b0000;
    bus.last      = 4'b0000;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle after reset.
    repeat (10) begin
      step();
      check("idle_grant", bus.grant, 4'b0000);
      check("idle_select", bus.select, 2'd0);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_out_valid", bus.out_valid, 1'b0);
    end

    // Single burst from requester 2, ended by last on beat 3.
    bus.req = 4'b0100;
    bus.out_ready = 1'b1;
    step();
    check("burst_grant", bus.grant, 4'b0100);
    check("burst_select", bus.select, 2'd2);
    step();
    step();
    bus.last = 4'b0100;
    step();
    bus.last = 4'b0000;
    check("burst_regrant_sole", bus.grant, 4'b0100);
    bus.req = 4'b0000;
    step();
    check("burst_to_idle", bus.grant, 4'b0000);

    // Rotation continues after requester 2, no gap cycles.
    bus.req = 4'b1111;
    step();
    check("fair_first", bus.grant, 4'b1000);
    repeat (MAX_BEATS) step();
    check("fair_second", bus.grant, 4'b0001);
    repeat (MAX_BEATS) step();
    check("fair_third", bus.grant, 4'b0010);

    // Backpressure holds requester 1.
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b1010;
    bus.out_ready = 1'b0;
    step();
    check("bp_grant", bus.grant, 4'b0010);
    repeat (20) step();
    check("bp_hold_grant", bus.grant, 4'b0010);
    check("bp_hold_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    repeat (MAX_BEATS) step();
    check("bp_handover", bus.grant, 4'b1000);

    // Abandon requester 3 after one beat.
    bus.req = 4'b1001;
    step();
    bus.req = 4'b0001;
    step();
    check("abandon_grant", bus.grant, 4'b0001);
    check("abandon_select", bus.select, 2'd0);

    // Asynchronous reset during requester 2's second beat.
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0100;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", bus.grant, 4'b0000);
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_valid", bus.out_valid, 1'b0);
    step();
    bus.req = 4'b1111;
    rst_n = 1'b1;
    step();
    check("post_rst_first", bus.grant, 4'b0001);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] flip;
      flip = 4'b0000;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 7) == 0);
      bus.req       = bus.req ^ flip;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.last      = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      step();
    end

    bus.req = 4'b0000;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
